fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the PC and data paths.
REQ-002 Parameter INSTRUCTION, 32, width of the instruction word.
REQ-003 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-004 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous assert, active-low; state is cleared while rst=0.
REQ-006 Port stall_i  input  1  decode cannot accept; 1 holds the output registers.
REQ-007 Port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-008 Port redirect_pc_i  input  DATA_WIDTH  redirect target.
REQ-009 Port imem_req_o  output  1  instruction memory request.
REQ-010 Port imem_addr_o  output  DATA_WIDTH  request address.
REQ-011 Port imem_ack_i  input  1  response valid; the data arrives in the same cycle.
REQ-012 Port imem_rdata_i  input  INSTRUCTION  response word.
REQ-013 Port instruction  output  INSTRUCTION  registered instruction to decode.
REQ-014 Port pc  output  DATA_WIDTH  PC of the instruction output.
REQ-015 Port fetch_valid  output  1  the instruction/pc outputs are valid.
REQ-016 Port misalign_o  output  1  sticky misaligned-redirect flag; tied 0 when the feature is compiled out.

Function
REQ-017 The FSM states SHALL be IDLE, FETCH, HOLD and DRAIN.
REQ-018 IDLE SHALL last exactly one cycle after reset release, with imem_req_o=0, and SHALL then go to FETCH.
REQ-019 In FETCH, imem_req_o SHALL be 1 and imem_addr_o SHALL equal fetch_pc.
REQ-020 While imem_req_o=1 and imem_ack_i=0, imem_addr_o SHALL stay stable.
REQ-021 Only one request SHALL be outstanding at a time.
REQ-022 On an ack in FETCH when the output is empty or consumed (stall_i=0), the outputs SHALL update on that edge as follows.
- instruction<=imem_rdata_i, pc<=fetch_pc, fetch_valid<=1, fetch_pc<=fetch_pc+4.
- The state SHALL remain FETCH, giving a throughput of one instruction per cycle.
REQ-023 On an ack in FETCH while fetch_valid=1 and stall_i=1, the word and its PC SHALL go to a one-entry skid buffer.
- fetch_pc SHALL advance by 4.
- The state SHALL go to HOLD, with imem_req_o=0.
REQ-024 In HOLD, when stall_i falls to 0, the skid entry SHALL move to the outputs on that edge and the state SHALL return to FETCH.
REQ-025 While stall_i=1 and no ack arrives, instruction, pc and fetch_valid SHALL hold their values.
REQ-026 When stall_i=0 and no new word is loaded, fetch_valid SHALL go to 0 on the next edge.
REQ-027 When redirect_i=1 in any state, the following SHALL happen on that edge.
- fetch_valid<=0, the skid buffer is cleared, and fetch_pc<=redirect_pc_i.
- Redirect SHALL take priority over stall_i.
REQ-028 A redirect while a request is pending (req=1, ack=0) SHALL go to DRAIN.
- In DRAIN, req and the old address SHALL be held until the ack.
- The data returned on that ack SHALL be discarded, then the state SHALL go to FETCH at the new fetch_pc.
REQ-029 A redirect in the same cycle as an ack SHALL discard that response and stay in FETCH at redirect_pc_i next cycle.
REQ-030 A redirect during DRAIN SHALL update fetch_pc only; the state SHALL remain DRAIN.
REQ-031 When fetch_valid=0, instruction SHALL read 32'h0000_0013 (NOP).
REQ-032 fetch_pc+4 SHALL wrap modulo 2^DATA_WIDTH.

Reset
REQ-033 While rst=0, the following SHALL hold.
- state=IDLE, fetch_pc=RESET_PC, fetch_valid=0, instruction=32'h0000_0013, pc=0.
- imem_req_o=0, imem_addr_o=RESET_PC, misalign_o=0, skid buffer empty.
REQ-034 Reset asserted mid-request SHALL abandon the request; any ack arriving during reset SHALL be ignored.

Configuration
REQ-035 The feature macro SHALL be FETCH_MISALIGN_CHECK_EN.
REQ-036 When the macro is defined, a redirect with redirect_pc_i[1:0]!=0 SHALL have the following effect.
- misalign_o<=1 and fetch_valid<=0.
- The FSM SHALL enter IDLE and stay there until reset.
REQ-037 When the macro is undefined, redirect_pc_i[1:0] SHALL be forced to 00 and misalign_o SHALL be tied 0.

Verification
REQ-038 Zero-wait memory (ack equal to req), no stall -> req rises 1 cycle after reset release; pc outputs 0x0, 0x4, 0x8 on consecutive cycles; fetch_valid=1 continuously.
REQ-039 Two-cycle ack latency with the address at 0x10 -> imem_addr_o stays 0x10 across the wait; pc=0x10 appears on the edge after the ack.
REQ-040 stall_i=1 for 3 cycles while an ack for 0x8 arrives -> outputs hold 0x4; the FSM enters HOLD; pc=0x8 on the edge stall falls; no word is lost or duplicated.
REQ-041 redirect_i=1 with target 0x100 while the request for 0x20 is pending -> the 0x20 data is discarded; the next valid pc=0x100; one or more bubble cycles show NOP.
REQ-042 Redirect and ack in the same cycle, with stall_i=1 -> fetch_valid=0 next cycle; the next request address is the target.
REQ-043 With FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> misalign_o=1, req stays 0 until reset. Without the macro -> the fetch goes to 0x100.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry skid buffer, redirect flush/drain.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets with a sticky misalign_o flag.
module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INSTRUCTION = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
  output logic                   imem_req_o,
  output logic [DATA_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTRUCTION-1:0] imem_rdata_i,
  output logic [INSTRUCTION-1:0] instruction,
  output logic [DATA_WIDTH-1:0]  pc,
  output logic                   fetch_valid,
  output logic                   misalign_o
);

  localparam logic [INSTRUCTION-1:0] NOP      = INSTRUCTION'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0]  LOW_MASK = DATA_WIDTH'(3);
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [DATA_WIDTH-1:0]  drain_addr_reg, drain_addr_next;
  logic [DATA_WIDTH-1:0]  pc_reg, pc_next;
  logic [DATA_WIDTH-1:0]  skid_pc_reg, skid_pc_next;
  logic [INSTRUCTION-1:0] instr_reg, instr_next;
  logic [INSTRUCTION-1:0] skid_instr_reg, skid_instr_next;
  logic                   valid_reg, valid_next;
  logic                   sticky_reg, sticky_next;
  logic [DATA_WIDTH-1:0]  target;
  logic                   bad_target;

  // Without the trap, the low target bits are simply dropped.
  assign target     = MISALIGN_EN ? redirect_pc_i : (redirect_pc_i & ~LOW_MASK);
  assign bad_target = MISALIGN_EN && (redirect_pc_i[1:0] != 2'b00);

  assign imem_req_o  = (state_reg == FETCH) || (state_reg == DRAIN);
  assign imem_addr_o = (state_reg == DRAIN) ? drain_addr_reg : fetch_pc_reg;
  assign instruction = valid_reg ? instr_reg : NOP;
  assign pc          = pc_reg;
  assign fetch_valid = valid_reg;
  assign misalign_o  = MISALIGN_EN ? sticky_reg : 1'b0;

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    drain_addr_next = drain_addr_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    valid_next      = valid_reg;
    skid_pc_next    = skid_pc_reg;
    skid_instr_next = skid_instr_reg;
    sticky_next     = sticky_reg;

    if (sticky_reg) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end else if (redirect_i) begin
      valid_next      = 1'b0;
      skid_pc_next    = '0;
      skid_instr_next = '0;
      if (bad_target) begin
        sticky_next = 1'b1;
        state_next  = IDLE;
      end else begin
        fetch_pc_next = target;
        case (state_reg)
          // An in-flight request must still complete; its data is dropped in DRAIN.
          FETCH: if (!imem_ack_i) begin
            state_next      = DRAIN;
            drain_addr_next = fetch_pc_reg;
          end
          DRAIN:   if (imem_ack_i) state_next = FETCH;
          default: state_next = FETCH;
        endcase
      end
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = FETCH;
          valid_next = 1'b0;
        end
        FETCH: begin
          if (imem_ack_i) begin
            fetch_pc_next = fetch_pc_reg + DATA_WIDTH'(4);
            if (valid_reg && stall_i) begin
              skid_pc_next    = fetch_pc_reg;
              skid_instr_next = imem_rdata_i;
              state_next      = HOLD;
            end else begin
              pc_next    = fetch_pc_reg;
              instr_next = imem_rdata_i;
              valid_next = 1'b1;
            end
          end else if (!stall_i) begin
            valid_next = 1'b0;
          end
        end
        HOLD: if (!stall_i) begin
          pc_next    = skid_pc_reg;
          instr_next = skid_instr_reg;
          valid_next = 1'b1;
          state_next = FETCH;
        end
        DRAIN: begin
          if (imem_ack_i) state_next = FETCH;
          if (!stall_i) valid_next = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      drain_addr_reg <= RESET_PC;
      pc_reg         <= '0;
      instr_reg      <= NOP;
      valid_reg      <= 1'b0;
      skid_pc_reg    <= '0;
      skid_instr_reg <= '0;
      sticky_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      drain_addr_reg <= drain_addr_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      valid_reg      <= valid_next;
      skid_pc_reg    <= skid_pc_next;
      skid_instr_reg <= skid_instr_next;
      sticky_reg     <= sticky_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against an
// in-order delivery scoreboard. Honours FETCH_MISALIGN_CHECK_EN when defined.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        stall_i = 1'b0, redirect_i = 1'b0, imem_ack_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic        imem_req_o, fetch_valid, misalign_o;
  logic [31:0] imem_addr_o, instruction, pc;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .INSTRUCTION(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instruction(instruction),
    .pc(pc), .fetch_valid(fetch_valid), .misalign_o(misalign_o)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic do_reset();
    rst = 1'b0; imem_ack_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one cycle of inputs (memory answers with the word for the current address).
  task automatic cycle(input logic ack, input logic stl, input logic rd, input logic [31:0] rpc);
    imem_ack_i = ack; imem_rdata_i = word_of(imem_addr_o);
    stall_i = stl; redirect_i = rd; redirect_pc_i = rpc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b expected 1", imem_req_o); end
    imem_ack_i = 1'b1; imem_rdata_i = word_of(32'h0); rst = 1'b0;
    #1;
    n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %b expected 0", imem_req_o); end
    repeat (2) @(negedge clk);
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", fetch_valid); end
    n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h expected %h", instruction, NOP); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", pc); end
    n_tests++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", imem_addr_o); end
    n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", misalign_o); end
    rst = 1'b1; imem_ack_i = 1'b0;
    #1;
    n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_req: got %b expected 0", imem_req_o); end
    @(negedge clk);
    n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_zero_wait();
    do_reset();
    #1;
    n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL zw_idle_req: got %b expected 0", imem_req_o); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(imem_req_o, 1'b0, 1'b0, 32'h0);
      n_tests++;
      if (fetch_valid !== 1'b1 || pc !== 32'(4 * i) || instruction !== word_of(32'(4 * i))) begin
        n_fail++; $display("FAIL zw_out[%0d]: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", i, fetch_valid, pc, instruction, 32'(4 * i), word_of(32'(4 * i)));
      end
    end
    $display("[TB] test_zero_wait done");
  endtask

  task automatic test_latency();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && imem_addr_o != 32'h10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (imem_addr_o !== 32'h10) begin n_fail++; $display("FAIL lat_reach: got %h expected 10", imem_addr_o); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_tests++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || fetch_valid !== 1'b0 || instruction !== NOP) begin
        n_fail++; $display("FAIL lat_wait[%0d]: got req=%b addr=%h v=%b ins=%h expected req=1 addr=10 v=0 ins=%h", i, imem_req_o, imem_addr_o, fetch_valid, instruction, NOP);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (fetch_valid !== 1'b1 || pc !== 32'h10 || instruction !== word_of(32'h10)) begin
      n_fail++; $display("FAIL lat_out: got v=%b pc=%h ins=%h expected v=1 pc=10 ins=%h", fetch_valid, pc, instruction, word_of(32'h10));
    end
    $display("[TB] test_latency done");
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (imem_addr_o !== 32'h8 || pc !== 32'h4) begin n_fail++; $display("FAIL st_setup: got addr=%h pc=%h expected addr=8 pc=4", imem_addr_o, pc); end
    for (int i = 0; i < 3; i++) begin
      cycle(i == 0, 1'b1, 1'b0, 32'h0);
      n_tests++;
      if (fetch_valid !== 1'b1 || pc !== 32'h4 || instruction !== word_of(32'h4) || imem_req_o !== 1'b0) begin
        n_fail++; $display("FAIL st_hold[%0d]: got v=%b pc=%h req=%b expected v=1 pc=4 req=0", i, fetch_valid, pc, imem_req_o);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++; if (fetch_valid !== 1'b1 || pc !== 32'h8 || instruction !== word_of(32'h8)) begin
      n_fail++; $display("FAIL st_release: got v=%b pc=%h ins=%h expected v=1 pc=8 ins=%h", fetch_valid, pc, instruction, word_of(32'h8));
    end
    n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL st_next_req: got req=%b addr=%h expected req=1 addr=c", imem_req_o, imem_addr_o); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (pc !== 32'hC || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL st_after: got v=%b pc=%h expected v=1 pc=c", fetch_valid, pc); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_redirect_pending();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && imem_addr_o != 32'h20; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h20 || fetch_valid !== 1'b0 || instruction !== NOP) begin
      n_fail++; $display("FAIL rp_drain: got req=%b addr=%h v=%b ins=%h expected req=1 addr=20 v=0 ins=%h", imem_req_o, imem_addr_o, fetch_valid, instruction, NOP);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (fetch_valid !== 1'b0 || instruction !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL rp_discard: got v=%b ins=%h req=%b addr=%h expected v=0 ins=%h req=1 addr=100", fetch_valid, instruction, imem_req_o, imem_addr_o, NOP);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (fetch_valid !== 1'b1 || pc !== 32'h100 || instruction !== word_of(32'h100)) begin
      n_fail++; $display("FAIL rp_target: got v=%b pc=%h ins=%h expected v=1 pc=100 ins=%h", fetch_valid, pc, instruction, word_of(32'h100));
    end
    $display("[TB] test_redirect_pending done");
  endtask

  task automatic test_redirect_ack_stall();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    n_tests++; if (fetch_valid !== 1'b0 || instruction !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL ras_flush: got v=%b ins=%h req=%b addr=%h expected v=0 ins=%h req=1 addr=200", fetch_valid, instruction, imem_req_o, imem_addr_o, NOP);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (fetch_valid !== 1'b1 || pc !== 32'h200) begin n_fail++; $display("FAIL ras_target: got v=%b pc=%h expected v=1 pc=200", fetch_valid, pc); end
    $display("[TB] test_redirect_ack_stall done");
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (pc !== 32'hFFFF_FFFC || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got pc=%h addr=%h expected pc=fffffffc addr=0", pc, imem_addr_o); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pc: got v=%b pc=%h expected v=1 pc=0", fetch_valid, pc); end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_misalign();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || fetch_valid !== 1'b0) begin
        n_fail++; $display("FAIL mis_trap[%0d]: got mis=%b req=%b v=%b expected mis=1 req=0 v=0", i, misalign_o, imem_req_o, fetch_valid);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
    end
    do_reset();
    #1;
    n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b expected 0", misalign_o); end
`else
    n_tests++; if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL mis_force: got mis=%b req=%b addr=%h expected mis=0 req=1 addr=100", misalign_o, imem_req_o, imem_addr_o);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (pc !== 32'h100 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL mis_fetch: got v=%b pc=%h expected v=1 pc=100", fetch_valid, pc); end
`endif
    $display("[TB] test_misalign done");
  endtask

  // Random traffic: every live (non-flushed) response must reach decode once, in order.
  task automatic test_random();
    item_t       q[$];
    item_t       it;
    logic [31:0] exp_addr, prev_addr, tgt;
    logic        stale, prev_pend, busy, stl, rd, ack, acc;
    int          wait_left, delivered;
    exp_addr = 32'h0; prev_addr = 32'h0; stale = 1'b0; prev_pend = 1'b0; busy = 1'b0;
    wait_left = 0; delivered = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_pend) begin
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
          n_fail++; $display("FAIL rnd_stable@%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, imem_req_o, imem_addr_o, prev_addr);
        end
      end
      n_tests++; if (fetch_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, fetch_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_tests++; if (pc !== q[0].pc || instruction !== q[0].data) begin
          n_fail++; $display("FAIL rnd_out@%0d: got pc=%h ins=%h expected pc=%h ins=%h", cyc, pc, instruction, q[0].pc, q[0].data);
        end
      end else begin
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL rnd_nop@%0d: got %h expected %h", cyc, instruction, NOP); end
      end
      if (q.size() == 2) begin
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rnd_full_req@%0d: got %b expected 0", cyc, imem_req_o); end
      end

      stl = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
`else
      tgt = $urandom();
`endif
      ack = 1'b0;
      if (imem_req_o) begin
        if (!busy) begin busy = 1'b1; wait_left = $urandom_range(0, 2); end
        ack = (wait_left == 0);
        if (ack) busy = 1'b0; else wait_left--;
      end else begin
        busy = 1'b0;
      end

      acc = ack && imem_req_o;
      if (acc && !rd && !stale) begin
        n_tests++; if (imem_addr_o !== exp_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", cyc, imem_addr_o, exp_addr); end
      end
      if (q.size() != 0 && !stl) begin void'(q.pop_front()); delivered++; end
      if (rd) begin
        q.delete();
        if (acc) stale = 1'b0; else if (imem_req_o) stale = 1'b1;
        exp_addr = {tgt[31:2], 2'b00};
      end else if (acc) begin
        if (stale) stale = 1'b0;
        else begin
          it.pc = imem_addr_o; it.data = word_of(imem_addr_o);
          q.push_back(it);
          exp_addr = exp_addr + 32'd4;
        end
      end
      prev_pend = imem_req_o && !ack;
      prev_addr = imem_addr_o;
      cycle(ack, stl, rd, tgt);
    end
    n_tests++; if (delivered < 300) begin n_fail++; $display("FAIL rnd_progress: got %0d delivered expected at least 300", delivered); end
    $display("[TB] test_random done, %0d words delivered", delivered);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_pending();
    test_redirect_ack_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
